wb_result_select: RTL and testbench



---
 rtl/wb_result_select.sv | 156 +++++++++++++++
 tb/tb_wb_result_select.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_select.sv
// Registered writeback result selector: takes one issued operation, waits for
// the selected functional unit's done pulse (or a timeout), then holds the
// tagged result under a valid/ready handshake until the register file takes it.
module wb_result_select #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned SEL_W     = $clog2(NUM_UNITS),
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [SEL_W-1:0]            issue_op,
    input  logic [TAG_W-1:0]            issue_tag,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_res,
    input  logic [NUM_UNITS-1:0]        unit_done,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_W-1:0]           rd_val,
    output logic [TAG_W-1:0]            rd_tag,
    output logic                        rd_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_val_q, rd_val_d;
    logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;
    logic               rd_err_q, rd_err_d;

    logic [SEL_W-1:0]   cur_op_c;
    logic [DATA_W-1:0]  sel_res_c;
    logic               sel_done_c;
    logic               op_legal_c;

    // Unit select: the issuing opcode in IDLE (fast path), the latched one otherwise.
    always_comb begin
        cur_op_c   = (state_q == S_IDLE) ? issue_op : op_q;
        sel_res_c  = '0;
        sel_done_c = 1'b0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (cur_op_c == SEL_W'(i)) begin
                sel_res_c  = unit_res[i*DATA_W +: DATA_W];
                sel_done_c = unit_done[i];
            end
        end
        op_legal_c = (32'(cur_op_c) < NUM_UNITS);
    end

    // Next-state and result capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        wait_cnt_d = wait_cnt_q;
        rd_valid_d = rd_valid_q;
        rd_val_d   = rd_val_q;
        rd_tag_d   = rd_tag_q;
        rd_err_d   = rd_err_q;

        case (state_q)
            S_IDLE: begin
                if (issue_valid) begin
                    op_d       = issue_op;
                    tag_d      = issue_tag;
                    wait_cnt_d = '0;
                    if (!op_legal_c) begin
                        state_d    = S_HOLD;
                        rd_valid_d = 1'b1;
                        rd_val_d   = '0;
                        rd_tag_d   = issue_tag;
                        rd_err_d   = 1'b1;
                    end else if (sel_done_c) begin
                        state_d    = S_HOLD;
                        rd_valid_d = 1'b1;
                        rd_val_d   = sel_res_c;
                        rd_tag_d   = issue_tag;
                        rd_err_d   = 1'b0;
                    end else begin
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Done takes priority over the timeout in the same cycle.
                if (sel_done_c) begin
                    state_d    = S_HOLD;
                    rd_valid_d = 1'b1;
                    rd_val_d   = sel_res_c;
                    rd_tag_d   = tag_q;
                    rd_err_d   = 1'b0;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = S_HOLD;
                    rd_valid_d = 1'b1;
                    rd_val_d   = '0;
                    rd_tag_d   = tag_q;
                    rd_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (rd_ready) begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            tag_q      <= '0;
            wait_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_val_q   <= '0;
            rd_tag_q   <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            wait_cnt_q <= wait_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_val_q   <= rd_val_d;
            rd_tag_q   <= rd_tag_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign issue_ready = (state_q == S_IDLE);
    assign rd_valid    = rd_valid_q;
    assign rd_val      = rd_val_q;
    assign rd_tag      = rd_tag_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_wb_result_select.sv
// Self-checking bench for wb_result_select: directed vectors, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_wb_result_select;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned TIMEOUT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Main instance: four units.
    logic        issue_valid, issue_ready;
    logic [1:0]  issue_op;
    logic [3:0]  issue_tag;
    logic [63:0] unit_res;
    logic [3:0]  unit_done;
    logic        rd_valid, rd_ready, rd_err;
    logic [15:0] rd_val;
    logic [3:0]  rd_tag;

    // Second instance: three units, so opcode 3 is illegal.
    logic        i3_valid, i3_ready;
    logic [1:0]  i3_op;
    logic [3:0]  i3_tag;
    logic [47:0] u3_res;
    logic [2:0]  u3_done;
    logic        r3_valid, r3_ready, r3_err;
    logic [15:0] r3_val;
    logic [3:0]  r3_tag;

    wb_result_select #(.DATA_W(DATA_W), .NUM_UNITS(NUM_UNITS), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_tag(issue_tag),
        .unit_res(unit_res), .unit_done(unit_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_val(rd_val), .rd_tag(rd_tag), .rd_err(rd_err)
    );

    wb_result_select #(.DATA_W(DATA_W), .NUM_UNITS(3), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut3 (
        .clk(clk), .rst(rst),
        .issue_valid(i3_valid), .issue_ready(i3_ready),
        .issue_op(i3_op), .issue_tag(i3_tag),
        .unit_res(u3_res), .unit_done(u3_done),
        .rd_valid(r3_valid), .rd_ready(r3_ready),
        .rd_val(r3_val), .rd_tag(r3_tag), .rd_err(r3_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(string nm, logic ev, logic [15:0] evl, logic [3:0] et, logic ee, logic er);
        chk({nm, ".rd_valid"},    32'(rd_valid),    32'(ev));
        chk({nm, ".rd_val"},      32'(rd_val),      32'(evl));
        chk({nm, ".rd_tag"},      32'(rd_tag),      32'(et));
        chk({nm, ".rd_err"},      32'(rd_err),      32'(ee));
        chk({nm, ".issue_ready"}, 32'(issue_ready), 32'(er));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic iv, logic [1:0] op, logic [3:0] tag, logic [63:0] res, logic [3:0] done, logic rdy);
        issue_valid = iv;
        issue_op    = op;
        issue_tag   = tag;
        unit_res    = res;
        unit_done   = done;
        rd_ready    = rdy;
    endtask

    // Transaction-level reference: a result appears when the selected unit
    // reports done, or once TIMEOUT waiting cycles have elapsed.
    bit          m_busy, m_hold;
    int          m_age, m_op;
    logic [3:0]  m_tag;
    logic        e_valid, e_err;
    logic [15:0] e_val;
    logic [3:0]  e_tag;

    task automatic model_reset();
        m_busy = 0; m_hold = 0; m_age = 0; m_op = 0; m_tag = '0;
        e_valid = 0; e_val = '0; e_tag = '0; e_err = 0;
    endtask

    task automatic deliver(logic [15:0] v, logic [3:0] t, logic e);
        m_busy = 0; m_hold = 1;
        e_valid = 1; e_val = v; e_tag = t; e_err = e;
    endtask

    task automatic model_step();
        if (m_hold) begin
            if (rd_ready) begin
                m_hold  = 0;
                e_valid = 0;
            end
        end else if (m_busy) begin
            m_age++;
            if (unit_done[m_op])     deliver(unit_res[m_op*DATA_W +: DATA_W], m_tag, 1'b0);
            else if (m_age == TIMEOUT) deliver(16'h0, m_tag, 1'b1);
        end else if (issue_valid) begin
            if (int'(issue_op) >= NUM_UNITS)
                deliver(16'h0, issue_tag, 1'b1);
            else if (unit_done[issue_op])
                deliver(unit_res[int'(issue_op)*DATA_W +: DATA_W], issue_tag, 1'b0);
            else begin
                m_busy = 1; m_op = int'(issue_op); m_tag = issue_tag; m_age = 0;
            end
        end
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  op;
        logic [3:0]  tag;
        logic [63:0] res;
        logic [3:0]  done;
        logic        rdy;
        logic        ev;
        logic [15:0] evl;
        logic [3:0]  et;
        logic        ee;
        logic        er;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Fast path, then a result held under four cycles of backpressure.
        tbl[0] = '{1'b1, 2'd0, 4'd3, 64'h0000_0000_0000_0005, 4'b0001, 1'b1, 1'b1, 16'h0005, 4'd3, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'd0, 4'd0, 64'h0000_0000_0000_0000, 4'b0000, 1'b1, 1'b0, 16'h0005, 4'd3, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 2'd1, 4'd9, 64'h0000_0000_1234_0000, 4'b0010, 1'b0, 1'b1, 16'h1234, 4'd9, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 2'd0, 4'd1, 64'h1111_2222_3333_4444, 4'b1111, 1'b0, 1'b1, 16'h1234, 4'd9, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 2'd1, 4'd2, 64'h5555_6666_7777_8888, 4'b0010, 1'b0, 1'b1, 16'h1234, 4'd9, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'd2, 4'd4, 64'h9999_AAAA_BBBB_CCCC, 4'b0100, 1'b0, 1'b1, 16'h1234, 4'd9, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 2'd3, 4'd5, 64'hDDDD_EEEE_FFFF_0001, 4'b1000, 1'b0, 1'b1, 16'h1234, 4'd9, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 2'd0, 4'd0, 64'h0000_0000_0000_0000, 4'b0000, 1'b1, 1'b0, 16'h1234, 4'd9, 1'b0, 1'b1};

        rst = 1'b1;
        drive(1'b0, 2'd0, 4'd0, 64'h0, 4'b0, 1'b0);
        i3_valid = 0; i3_op = '0; i3_tag = '0; u3_res = '0; u3_done = '0; r3_ready = 0;
        tick();
        chk_out("reset", 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        chk("reset.r3_valid", 32'(r3_valid), 32'd0);
        rst = 1'b0;
        tick();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].iv, tbl[i].op, tbl[i].tag, tbl[i].res, tbl[i].done, tbl[i].rdy);
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].evl, tbl[i].et, tbl[i].ee, tbl[i].er);
        end

        // Multi-cycle: unit 3 done 5 cycles after accept, unit 2 distractor at 2.
        for (int c = 0; c <= 5; c++) begin
            drive(c == 0, 2'd3, 4'd7, 64'h00AA_BEEF_0000_0000,
                  (c == 5) ? 4'b1000 : ((c == 2) ? 4'b0100 : 4'b0000), 1'b1);
            tick();
            if (c < 5) chk_out($sformatf("multi.c%0d", c), 1'b0, 16'h1234, 4'd9, 1'b0, 1'b0);
            else       chk_out("multi.done", 1'b1, 16'h00AA, 4'd7, 1'b0, 1'b0);
        end
        drive(1'b0, 2'd0, 4'd0, 64'h0, 4'b0, 1'b1);
        tick();
        chk_out("multi.release", 1'b0, 16'h00AA, 4'd7, 1'b0, 1'b1);

        // Timeout: unit 2 never completes; other units pulse and are ignored.
        for (int c = 0; c <= 16; c++) begin
            drive(c == 0, 2'd2, 4'd5, 64'hABCD_0000_1111_2222, (c == 0) ? 4'b0000 : 4'b1011, 1'b0);
            tick();
            if (c < 16) chk("timeout.wait.rd_valid", 32'(rd_valid), 32'd0);
            else        chk_out("timeout.err", 1'b1, 16'h0, 4'd5, 1'b1, 1'b0);
        end
        drive(1'b0, 2'd0, 4'd0, 64'h0, 4'b0, 1'b1);
        tick();
        chk_out("timeout.release", 1'b0, 16'h0, 4'd5, 1'b1, 1'b1);

        // Done arriving on the last waiting cycle beats the timeout.
        for (int c = 0; c <= 16; c++) begin
            drive(c == 0, 2'd1, 4'd2, 64'h0000_0000_7777_0000, (c == 16) ? 4'b0010 : 4'b0000, 1'b0);
            tick();
            if (c < 16) chk("race.wait.rd_valid", 32'(rd_valid), 32'd0);
            else        chk_out("race.done", 1'b1, 16'h7777, 4'd2, 1'b0, 1'b0);
        end
        drive(1'b0, 2'd0, 4'd0, 64'h0, 4'b0, 1'b1);
        tick();

        // Illegal opcode on the three-unit instance, then a legal fast path.
        i3_valid = 1; i3_op = 2'd3; i3_tag = 4'hC; u3_res = 48'h1234_5678_9ABC; u3_done = 3'b111;
        tick();
        chk("illegal.r3_valid", 32'(r3_valid), 32'd1);
        chk("illegal.r3_err",   32'(r3_err),   32'd1);
        chk("illegal.r3_val",   32'(r3_val),   32'd0);
        chk("illegal.r3_tag",   32'(r3_tag),   32'hC);
        chk("illegal.i3_ready", 32'(i3_ready), 32'd0);
        i3_valid = 0; u3_done = '0; r3_ready = 1;
        tick();
        chk("illegal.release.r3_valid", 32'(r3_valid), 32'd0);
        chk("illegal.release.i3_ready", 32'(i3_ready), 32'd1);
        i3_valid = 1; i3_op = 2'd2; i3_tag = 4'h1; u3_res = 48'h3C3C_0000_0000; u3_done = 3'b100;
        tick();
        chk("legal3.r3_val", 32'(r3_val), 32'h3C3C);
        chk("legal3.r3_err", 32'(r3_err), 32'd0);
        i3_valid = 0; u3_done = '0;
        tick();

        // Reset two cycles after accept aborts the operation immediately.
        drive(1'b1, 2'd3, 4'd6, 64'h0, 4'b0, 1'b0);
        tick();
        drive(1'b0, 2'd3, 4'd6, 64'h0, 4'b0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk_out("rstwait", 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 4'd0, 64'h5555_0000_0000_0000, 4'b1000, 1'b0);
        tick();
        drive(1'b0, 2'd0, 4'd0, 64'h0, 4'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out("rstwait.after", 1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
        end

        // Randomized traffic against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] d;
            for (int u = 0; u < 4; u++) d[u] = ($urandom_range(0, 11) == 0);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                  {$urandom, $urandom}, d, 1'($urandom_range(0, 1)));
            model_step();
            tick();
            chk_out("rand", e_valid, e_val, e_tag, e_err, !(m_busy || m_hold));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
